fp_int_norm: RTL and testbench

Converts the accumulator's result back to FP16. The input is a signed fixed-point value with a shared exponent: 32-bit two's-complement `fixed_point` plus a 5-bit exponent. The block normalizes it with a sequential leading-one search, rounds to nearest-even and packs an IEEE-754 binary16 word. It sits downstream of the FP-INT accumulator and reads the accumulator's `exp_out`/`fixed_point_out` pair once accumulation is done.

---
 rtl/fp_int_norm.sv | 162 ++++++++++++++++
 tb/tb_fp_int_norm.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_int_norm.sv
// Converts a shared-exponent signed fixed-point value to IEEE-754 binary16.
// Normalisation is a one-bit-per-cycle leading-one search; rounding is nearest-even.
module fp_int_norm #(
  parameter int FRAC_BITS = 10,
  parameter int BIAS      = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  exp_in,
  input  logic [31:0] fixed_point_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] fp_out,
  output logic        overflow,
  output logic        underflow,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2
  } state_t;

  // start/busy handshake: start is only looked at while busy is low (IDLE);
  // a start seen in IDLE at a rising edge is accepted and the inputs are
  // captured on that edge. done pulses for one cycle per accepted start,
  // in the same cycle busy falls, and a start in that cycle is accepted.

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic        zero_q, zero_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  exp_q, exp_d;
  logic [5:0]  sh_q, sh_d;
  logic        done_q, done_d;
  logic [15:0] fp_q, fp_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  logic [31:0] mag_in;
  logic [15:0] rnd_fp;
  logic        rnd_ovf;
  logic        rnd_unf;

  // 0x80000000 negates to itself, which reads correctly as 2^31 unsigned.
  assign mag_in = fixed_point_in[31] ? (~fixed_point_in + 32'd1) : fixed_point_in;

  always_comb begin
    logic [9:0]  m;
    logic        g;
    logic        s;
    logic        round_up;
    logic [10:0] m_rnd;
    int          e_val;
    logic [4:0]  e_fld;

    m        = mag_q[30:21];
    g        = mag_q[20];
    s        = |mag_q[19:0];
    round_up = g & (s | m[0]);
    m_rnd    = {1'b0, m} + {10'd0, round_up};
    // Unbias the shared exponent and rebias for FP16; both use BIAS.
    e_val    = (int'(exp_q) - BIAS) + BIAS + 31 - FRAC_BITS - int'(sh_q);
    if (m_rnd[10]) begin
      e_val = e_val + 1;
    end
    e_fld   = 5'(e_val);
    rnd_fp  = 16'h0000;
    rnd_ovf = 1'b0;
    rnd_unf = 1'b0;
    if (zero_q) begin
      rnd_fp = 16'h0000;
    end else if (e_val >= 31) begin
      rnd_fp  = {sign_q, 5'h1F, 10'h000};
      rnd_ovf = 1'b1;
    end else if (e_val <= 0) begin
      rnd_fp  = {sign_q, 15'h0000};
      rnd_unf = 1'b1;
    end else begin
      rnd_fp = {sign_q, e_fld, m_rnd[9:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    sh_d    = sh_q;
    done_d  = 1'b0;
    fp_d    = fp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d  = fixed_point_in[31];
          mag_d   = mag_in;
          exp_d   = exp_in;
          sh_d    = 6'd0;
          zero_d  = (mag_in == 32'd0);
          state_d = (mag_in == 32'd0) ? S_ROUND : S_NORM;
        end
      end
      S_NORM: begin
        if (mag_q[31]) begin
          state_d = S_ROUND;
        end else begin
          mag_d = {mag_q[30:0], 1'b0};
          sh_d  = sh_q + 6'd1;
        end
      end
      S_ROUND: begin
        fp_d    = rnd_fp;
        ovf_d   = rnd_ovf;
        unf_d   = rnd_unf;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      mag_q   <= 32'd0;
      exp_q   <= 5'd0;
      sh_q    <= 6'd0;
      done_q  <= 1'b0;
      fp_q    <= 16'h0000;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      sh_q    <= sh_d;
      done_q  <= done_d;
      fp_q    <= fp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign fp_out    = fp_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fp_int_norm.sv
// Directed bench for fp_int_norm: latency, rounding, saturation, handshake and reset abort.
module tb_fp_int_norm;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  exp_in;
  logic [31:0] fixed_point_in;
  logic        busy;
  logic        done;
  logic [15:0] fp_out;
  logic        overflow;
  logic        underflow;
  logic [1:0]  dbg_state;

  int tests_run;
  int tests_failed;

  fp_int_norm #(.FRAC_BITS(10), .BIAS(15)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .exp_in         (exp_in),
    .fixed_point_in (fixed_point_in),
    .busy           (busy),
    .done           (done),
    .fp_out         (fp_out),
    .overflow       (overflow),
    .underflow      (underflow),
    .dbg_state      (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers: called at 1ns after a rising edge; return 1ns after an edge.
  task automatic start_conv(input logic [31:0] fx, input logic [4:0] e);
    start          = 1'b1;
    fixed_point_in = fx;
    exp_in         = e;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b0;
    exp_in = 5'd0;
    fixed_point_in = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b exp 0", done); end
    tests_run++; if (fp_out !== 16'h0000) begin tests_failed++; $display("FAIL reset_fp got %h exp 0000", fp_out); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    tests_run++; if (underflow !== 1'b0) begin tests_failed++; $display("FAIL reset_unf got %b exp 0", underflow); end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int lat;
    start_conv(32'h0000_0400, 5'd15);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy got %b exp 1", busy); end
    wait_done(lat);
    tests_run++; if (lat != 23) begin tests_failed++; $display("FAIL basic_lat got %0d exp 23", lat); end
    tests_run++; if (fp_out !== 16'h3C00) begin tests_failed++; $display("FAIL basic_fp got %h exp 3c00", fp_out); end
    tests_run++; if ({overflow, underflow} !== 2'b00) begin tests_failed++; $display("FAIL basic_flags got %b exp 00", {overflow, underflow}); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_fall got %b exp 0", busy); end
    @(posedge clk);
    #1;
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_width got %b exp 0", done); end
    tests_run++; if (fp_out !== 16'h3C00) begin tests_failed++; $display("FAIL basic_fp_hold got %h exp 3c00", fp_out); end
    start_conv(32'hFFFF_FC00, 5'd15);
    wait_done(lat);
    tests_run++; if (lat != 23) begin tests_failed++; $display("FAIL neg_lat got %0d exp 23", lat); end
    tests_run++; if (fp_out !== 16'hBC00) begin tests_failed++; $display("FAIL neg_fp got %h exp bc00", fp_out); end
  endtask

  task automatic test_zero();
    int lat;
    start_conv(32'h0000_0000, 5'd7);
    wait_done(lat);
    tests_run++; if (lat != 1) begin tests_failed++; $display("FAIL zero_lat got %0d exp 1", lat); end
    tests_run++; if (fp_out !== 16'h0000) begin tests_failed++; $display("FAIL zero_fp got %h exp 0000", fp_out); end
    tests_run++; if ({overflow, underflow} !== 2'b00) begin tests_failed++; $display("FAIL zero_flags got %b exp 00", {overflow, underflow}); end
    start_conv(32'h8000_0000, 5'd0);
    wait_done(lat);
    tests_run++; if (lat != 2) begin tests_failed++; $display("FAIL minneg_lat got %0d exp 2", lat); end
    tests_run++; if (fp_out !== 16'hD400) begin tests_failed++; $display("FAIL minneg_fp got %h exp d400", fp_out); end
  endtask

  task automatic test_rounding();
    logic [31:0] vin [4];
    logic [15:0] vexp [4];
    int          vlat [4];
    int          lat;
    vin[0] = 32'h1002; vexp[0] = 16'h4400; vlat[0] = 21;
    vin[1] = 32'h1006; vexp[1] = 16'h4402; vlat[1] = 21;
    vin[2] = 32'h1003; vexp[2] = 16'h4401; vlat[2] = 21;
    vin[3] = 32'h0FFF; vexp[3] = 16'h4400; vlat[3] = 22;
    for (int i = 0; i < 4; i++) begin
      start_conv(vin[i], 5'd15);
      wait_done(lat);
      tests_run++; if (fp_out !== vexp[i]) begin tests_failed++; $display("FAIL round_fp[%0d] in %h got %h exp %h", i, vin[i], fp_out, vexp[i]); end
      tests_run++; if (lat != vlat[i]) begin tests_failed++; $display("FAIL round_lat[%0d] got %0d exp %0d", i, lat, vlat[i]); end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] vin [3];
    logic [4:0]  vex [3];
    logic [17:0] vexp [3];
    int          lat;
    vin[0] = 32'h7FFF_FFFF; vex[0] = 5'd31; vexp[0] = {16'h7C00, 2'b10};
    vin[1] = 32'h0000_0001; vex[1] = 5'd0;  vexp[1] = {16'h0000, 2'b01};
    vin[2] = 32'hFFFF_FFFF; vex[2] = 5'd0;  vexp[2] = {16'h8000, 2'b01};
    for (int i = 0; i < 3; i++) begin
      start_conv(vin[i], vex[i]);
      wait_done(lat);
      tests_run++;
      if ({fp_out, overflow, underflow} !== vexp[i]) begin
        tests_failed++;
        $display("FAIL sat[%0d] got fp=%h ovf=%b unf=%b exp fp=%h ovf=%b unf=%b",
                 i, fp_out, overflow, underflow, vexp[i][17:2], vexp[i][1], vexp[i][0]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int done_cnt;
    int done_at;
    done_cnt = 0;
    done_at  = -1;
    start_conv(32'h0000_0400, 5'd15);
    for (int c = 1; c <= 40; c++) begin
      start = 1'b0;
      if (c == 5 || c == 10) begin
        start          = 1'b1;
        fixed_point_in = 32'h0000_0001;
        exp_in         = 5'd0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        done_cnt++;
        done_at = c;
      end
    end
    start = 1'b0;
    tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL ignore_count got %0d exp 1", done_cnt); end
    tests_run++; if (done_at != 23) begin tests_failed++; $display("FAIL ignore_lat got %0d exp 23", done_at); end
    tests_run++; if (fp_out !== 16'h3C00) begin tests_failed++; $display("FAIL ignore_fp got %h exp 3c00", fp_out); end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_conv(32'h0000_1002, 5'd15);
    wait_done(lat);
    tests_run++; if (!(done === 1'b1 && fp_out === 16'h4400)) begin tests_failed++; $display("FAIL b2b_first got done=%b fp=%h exp done=1 fp=4400", done, fp_out); end
    start_conv(32'h8000_0000, 5'd0);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_no_gap got busy=%b exp 1", busy); end
    wait_done(lat);
    tests_run++; if (lat != 2) begin tests_failed++; $display("FAIL b2b_lat got %0d exp 2", lat); end
    tests_run++; if (fp_out !== 16'hD400) begin tests_failed++; $display("FAIL b2b_fp got %h exp d400", fp_out); end
  endtask

  task automatic test_reset_abort();
    int lat;
    int stray;
    stray = 0;
    start_conv(32'h0000_0400, 5'd15);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, fp_out, overflow, underflow} !== 19'd0) begin
      tests_failed++;
      $display("FAIL abort_outputs got busy=%b done=%b fp=%h ovf=%b unf=%b exp all 0",
               busy, done, fp_out, overflow, underflow);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) stray++;
    end
    tests_run++; if (stray != 0) begin tests_failed++; $display("FAIL abort_stray got %0d exp 0", stray); end
    start_conv(32'h0000_1003, 5'd15);
    wait_done(lat);
    tests_run++; if (lat != 21) begin tests_failed++; $display("FAIL abort_after_lat got %0d exp 21", lat); end
    tests_run++; if (fp_out !== 16'h4401) begin tests_failed++; $display("FAIL abort_after_fp got %h exp 4401", fp_out); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_zero();
    test_rounding();
    test_saturation();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
